quad_input_filter: RTL and testbench
====================================

// Module: quad_input_filter
// PURPOSE
//  Front-end conditioning stage for the quadrature decoder. Synchronises raw encoder
//  channels A/B into clk, rejects glitches shorter than FILT_CYCLES, and drives clean
//  A/B into the decoder's A/B inputs. Flags Gray-code violations (both channels
//  changing together) and counts rejected glitches for diagnostics.
// PARAMETERS
//  SYNC_STAGES  2    flip-flop synchroniser depth per channel (>=2)
//  FILT_CYCLES  100  consecutive stable cycles required to accept a level (1 us @ 100 MHz, >=1)
//  CNT_W        16   width of glitch_cnt
// PORTS
//  clk         in   1      system clock (100 MHz)
//  rst         in   1      asynchronous, active-low reset
//  a_raw       in   1      encoder channel A, asynchronous to clk
//  b_raw       in   1      encoder channel B, asynchronous to clk
//  en          in   1      1 = filtering active; 0 = hold filtered outputs
//  err_clr     in   1      synchronous clear of err_illegal and glitch_cnt
//  a_filt      out  1      filtered A, to decoder A input
//  b_filt      out  1      filtered B, to decoder B input
//  edge_stb    out  1      1-cycle pulse when a_filt or b_filt changes
//  err_illegal out  1      sticky: a_filt and b_filt changed on the same edge
//  glitch_cnt  out  CNT_W  saturating count of rejected glitches
// BEHAVIOUR
//  Reset (rst=0, async): sync chains, counters, a_filt, b_filt, edge_stb, err_illegal,
//   glitch_cnt all 0; FSM -> INIT.
//  FSM: INIT -> RUN after SYNC_STAGES edges post-reset release. On the INIT->RUN edge,
//   a_filt/b_filt load synchroniser outputs directly: no edge_stb, no error, no glitch count.
//  Synchroniser: a_raw/b_raw each pass SYNC_STAGES FFs; only the last stage is used.
//  Per-channel filter (RUN, en=1), s = sync out, f = filtered out, c = counter:
//   s != f and c <  FILT_CYCLES-1 : c <= c+1
//   s != f and c == FILT_CYCLES-1 : f <= s, c <= 0
//   s == f and c != 0             : c <= 0, glitch event (rejected pulse)
//   s == f and c == 0             : hold
//  Latency: a clean level change on a_raw held stable is reflected on a_filt at the
//   (SYNC_STAGES+FILT_CYCLES)-th rising edge, counting the first edge that samples it as 1.
//   A pulse of fewer than FILT_CYCLES synchronised cycles never reaches a_filt.
//  edge_stb: registered; high the cycle after either filtered output changes, one cycle only.
//  err_illegal: set when both channels update on the same edge; both outputs still update
//   and one edge_stb is issued. Stays set until err_clr. Set has priority over err_clr
//   on the same cycle.
//  glitch_cnt: +1 per glitch event per channel (+2 if both on the same edge); saturates
//   at 2^CNT_W-1, no wrap. err_clr zeroes it; a same-cycle glitch event gives 0 + events.
//  en=0: a_filt/b_filt hold, counters forced to 0, no glitch events, no edge_stb.
//   Synchronisers keep running. On en 0->1, filtering restarts from c=0.
//  Async reset mid-filter discards all pending counts; INIT repeats.
//  Outputs are purely registered; no combinational path from inputs.
// TESTING
//  1 Reset with a_raw=1,b_raw=1; release -> after SYNC_STAGES edges a_filt=b_filt=1,
//    edge_stb=0, err_illegal=0, glitch_cnt=0.
//  2 a_raw 0->1 held, FILT_CYCLES=100 -> a_filt rises at edge 102 exactly, edge_stb one
//    cycle later for 1 cycle.
//  3 a_raw high pulse of 50 cycles -> a_filt stays 0, glitch_cnt=1; 99-cycle pulse also
//    rejected; 100-cycle pulse accepted.
//  4 a_raw and b_raw toggled on the same cycle -> both filtered outputs change on the same
//    edge, err_illegal=1, single edge_stb; err_clr pulse -> err_illegal=0, glitch_cnt=0.
//  5 Full quadrature sequence 00->01->11->10->00, 200 cycles/step -> 4 edge_stb, no error,
//    decoder receives clean Gray sequence.
//  6 en=0 during a pending change then rst asserted mid-count -> outputs hold, then all 0
//    asynchronously; CNT_W=4 with 20 glitches -> glitch_cnt saturates at 15.

Source files
------------

// File: rtl/quad_input_filter.sv
// quad_input_filter: synchronises and de-glitches encoder A/B for the
// quadrature decoder, flagging Gray-code violations and counting glitches.

// One encoder channel: synchroniser chain plus stable-level filter.
module qif_channel #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    input  logic load_i,
    input  logic run_i,
    output logic filt_o,
    output logic upd_o,
    output logic glitch_o
);
    localparam int FC_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [FC_W-1:0] LAST = FC_W'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;
    logic                   s_nxt;
    logic                   f_q;
    logic                   f_d;
    logic [FC_W-1:0]        c_q;
    logic [FC_W-1:0]        c_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    assign s      = sync_q[SYNC_STAGES-1];
    // Value the last stage captures on this edge, used for the INIT load
    assign s_nxt  = sync_q[SYNC_STAGES-2];
    assign filt_o = f_q;

    // Filter next state: count disagreement, accept after FILT_CYCLES
    always_comb begin
        f_d      = f_q;
        c_d      = c_q;
        upd_o    = 1'b0;
        glitch_o = 1'b0;
        if (load_i) begin
            f_d = s_nxt;
            c_d = '0;
        end else if (!run_i) begin
            c_d = '0;
        end else if (s != f_q) begin
            if (c_q == LAST) begin
                f_d   = s;
                c_d   = '0;
                upd_o = 1'b1;
            end else begin
                c_d = c_q + 1'b1;
            end
        end else if (c_q != '0) begin
            c_d      = '0;
            glitch_o = 1'b1;
        end
    end

    // Synchroniser, filtered level and stability counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            f_q    <= 1'b0;
            c_q    <= '0;
        end else begin
            sync_q <= sync_d;
            f_q    <= f_d;
            c_q    <= c_d;
        end
    end
endmodule

module quad_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 100,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_raw,
    input  logic             b_raw,
    input  logic             en,
    input  logic             err_clr,
    output logic             a_filt,
    output logic             b_filt,
    output logic             edge_stb,
    output logic             err_illegal,
    output logic [CNT_W-1:0] glitch_cnt
);
    localparam int IC_W = $clog2(SYNC_STAGES + 1);
    localparam logic [IC_W-1:0] INIT_LAST = IC_W'(SYNC_STAGES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [IC_W-1:0]  init_q;
    logic [IC_W-1:0]  init_d;
    logic             load;
    logic             run;
    logic             a_upd;
    logic             b_upd;
    logic             a_gl;
    logic             b_gl;
    logic             chg_q;
    logic             chg_d;
    logic             stb_q;
    logic             stb_d;
    logic             err_q;
    logic             err_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W+1:0] cnt_sum;

    qif_channel #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_CYCLES(FILT_CYCLES)
    ) u_a (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (a_raw),
        .load_i  (load),
        .run_i   (run),
        .filt_o  (a_filt),
        .upd_o   (a_upd),
        .glitch_o(a_gl)
    );

    qif_channel #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_CYCLES(FILT_CYCLES)
    ) u_b (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (b_raw),
        .load_i  (load),
        .run_i   (run),
        .filt_o  (b_filt),
        .upd_o   (b_upd),
        .glitch_o(b_gl)
    );

    assign run         = (state_q == RUN) && en;
    assign edge_stb    = stb_q;
    assign err_illegal = err_q;
    assign glitch_cnt  = cnt_q;

    // Startup sequencing: wait for the synchronisers to fill, then load
    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        load    = 1'b0;
        unique case (state_q)
            INIT: begin
                if (init_q == INIT_LAST) begin
                    state_d = RUN;
                    init_d  = '0;
                    load    = 1'b1;
                end else begin
                    init_d = init_q + 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
                init_d  = '0;
            end
        endcase
    end

    // Strobe pipeline, sticky Gray error and saturating glitch counter
    always_comb begin
        chg_d    = a_upd | b_upd;
        stb_d    = chg_q;
        err_d    = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (a_upd && b_upd) begin
            err_d = 1'b1;
        end
        cnt_base = err_clr ? '0 : cnt_q;
        cnt_sum  = {2'b00, cnt_base}
                 + {{(CNT_W+1){1'b0}}, a_gl}
                 + {{(CNT_W+1){1'b0}}, b_gl};
        if (cnt_sum > {2'b00, CNT_MAX}) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = cnt_sum[CNT_W-1:0];
        end
    end

    // Control and diagnostic registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            init_q  <= '0;
            chg_q   <= 1'b0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            chg_q   <= chg_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_quad_input_filter.sv
// tb_quad_input_filter: directed stimulus with an edge_stb-driven
// scoreboard for quad_input_filter.
module tb_quad_input_filter;
    logic        clk;
    logic        rst;
    logic        a_raw;
    logic        b_raw;
    logic        en;
    logic        err_clr;
    logic        a_filt;
    logic        b_filt;
    logic        edge_stb;
    logic        err_illegal;
    logic [15:0] glitch_cnt;

    logic        rst2;
    logic        a2;
    logic        b2;
    logic        en2;
    logic        clr2;
    logic        a_filt2;
    logic        b_filt2;
    logic        stb2;
    logic        err2;
    logic [3:0]  cnt2;

    int cyc;
    int n_pass;
    int n_tot;

    typedef struct {
        logic a;
        logic b;
        logic e;
        int   at;
    } exp_t;

    exp_t exq[$];

    quad_input_filter #(
        .SYNC_STAGES(2),
        .FILT_CYCLES(100),
        .CNT_W(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_raw      (a_raw),
        .b_raw      (b_raw),
        .en         (en),
        .err_clr    (err_clr),
        .a_filt     (a_filt),
        .b_filt     (b_filt),
        .edge_stb   (edge_stb),
        .err_illegal(err_illegal),
        .glitch_cnt (glitch_cnt)
    );

    quad_input_filter #(
        .SYNC_STAGES(2),
        .FILT_CYCLES(4),
        .CNT_W(4)
    ) dut2 (
        .clk        (clk),
        .rst        (rst2),
        .a_raw      (a2),
        .b_raw      (b2),
        .en         (en2),
        .err_clr    (clr2),
        .a_filt     (a_filt2),
        .b_filt     (b_filt2),
        .edge_stb   (stb2),
        .err_illegal(err2),
        .glitch_cnt (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s got=%0d want=%0d (cyc %0d)", nm, act, exp, cyc);
    endfunction

    task automatic push(logic a, logic b, logic e, int at);
        exp_t x;
        x.a  = a;
        x.b  = b;
        x.e  = e;
        x.at = at;
        exq.push_back(x);
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every edge_stb consumes one expected filtered-output event
    always @(negedge clk) begin
        exp_t x;
        if (rst && edge_stb) begin
            if (exq.size() == 0) begin
                chk("stray_edge_stb", 1, 0);
            end else begin
                x = exq.pop_front();
                chk("stb_cycle", cyc, x.at);
                chk("stb_a_filt", int'(a_filt), int'(x.a));
                chk("stb_b_filt", int'(b_filt), int'(x.b));
                chk("stb_err", int'(err_illegal), int'(x.e));
            end
        end
    end

    initial begin
        int t0;
        cyc     = 0;
        n_pass  = 0;
        n_tot   = 0;
        rst     = 1'b0;
        rst2    = 1'b0;
        a_raw   = 1'b1;
        b_raw   = 1'b1;
        en      = 1'b1;
        err_clr = 1'b0;
        a2      = 1'b0;
        b2      = 1'b0;
        en2     = 1'b1;
        clr2    = 1'b0;

        // Reset held with raw inputs high
        tick(3);
        chk("rst_a_filt", int'(a_filt), 0);
        chk("rst_b_filt", int'(b_filt), 0);
        chk("rst_stb", int'(edge_stb), 0);
        chk("rst_err", int'(err_illegal), 0);
        chk("rst_cnt", int'(glitch_cnt), 0);
        rst  = 1'b1;
        rst2 = 1'b1;
        tick(1);
        chk("init_edge1_a", int'(a_filt), 0);
        tick(1);
        chk("init_edge2_a", int'(a_filt), 1);
        chk("init_edge2_b", int'(b_filt), 1);
        chk("init_stb", int'(edge_stb), 0);
        chk("init_err", int'(err_illegal), 0);
        chk("init_cnt", int'(glitch_cnt), 0);
        tick(5);

        // Both channels change together: Gray violation
        a_raw = 1'b0;
        b_raw = 1'b0;
        t0 = cyc;
        push(1'b0, 1'b0, 1'b1, t0 + 103);
        tick(110);
        chk("both_err", int'(err_illegal), 1);
        chk("both_cnt", int'(glitch_cnt), 0);

        // 50 and 99 cycle pulses are rejected
        a_raw = 1'b1;
        tick(50);
        a_raw = 1'b0;
        tick(10);
        chk("g50_a_filt", int'(a_filt), 0);
        chk("g50_cnt", int'(glitch_cnt), 1);
        a_raw = 1'b1;
        tick(99);
        a_raw = 1'b0;
        tick(10);
        chk("g99_a_filt", int'(a_filt), 0);
        chk("g99_cnt", int'(glitch_cnt), 2);
        chk("g99_err_sticky", int'(err_illegal), 1);

        // Clear diagnostics
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("clr_err", int'(err_illegal), 0);
        chk("clr_cnt", int'(glitch_cnt), 0);
        tick(5);

        // Exact latency of a held rising edge on A
        a_raw = 1'b1;
        t0 = cyc;
        push(1'b1, 1'b0, 1'b0, t0 + 103);
        tick(101);
        chk("lat_edge101", int'(a_filt), 0);
        tick(1);
        chk("lat_edge102", int'(a_filt), 1);
        tick(10);

        // 100 cycle low pulse is accepted, then A returns high
        a_raw = 1'b0;
        t0 = cyc;
        push(1'b0, 1'b0, 1'b0, t0 + 103);
        push(1'b1, 1'b0, 1'b0, t0 + 203);
        tick(100);
        a_raw = 1'b1;
        tick(120);
        chk("p100_a_filt", int'(a_filt), 1);
        chk("p100_cnt", int'(glitch_cnt), 0);

        // Quadrature walk 10 -> 00 -> 01 -> 11 -> 10 -> 00
        a_raw = 1'b0;
        push(1'b0, 1'b0, 1'b0, cyc + 103);
        tick(200);
        b_raw = 1'b1;
        push(1'b0, 1'b1, 1'b0, cyc + 103);
        tick(200);
        a_raw = 1'b1;
        push(1'b1, 1'b1, 1'b0, cyc + 103);
        tick(200);
        b_raw = 1'b0;
        push(1'b1, 1'b0, 1'b0, cyc + 103);
        tick(200);
        a_raw = 1'b0;
        push(1'b0, 1'b0, 1'b0, cyc + 103);
        tick(200);
        chk("quad_err", int'(err_illegal), 0);
        chk("quad_cnt", int'(glitch_cnt), 0);
        chk("quad_pending", exq.size(), 0);

        // en=0 during a pending change holds output, no glitch
        a_raw = 1'b1;
        tick(50);
        en = 1'b0;
        tick(200);
        chk("en0_a_hold", int'(a_filt), 0);
        chk("en0_cnt", int'(glitch_cnt), 0);
        en = 1'b1;
        t0 = cyc;
        push(1'b1, 1'b0, 1'b0, t0 + 101);
        tick(110);
        chk("en1_a_filt", int'(a_filt), 1);

        // Async reset in the middle of a pending B change
        b_raw = 1'b1;
        tick(50);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_a_filt", int'(a_filt), 0);
        chk("arst_b_filt", int'(b_filt), 0);
        chk("arst_stb", int'(edge_stb), 0);
        chk("arst_err", int'(err_illegal), 0);
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("rinit_edge1_b", int'(b_filt), 0);
        tick(1);
        chk("rinit_a", int'(a_filt), 1);
        chk("rinit_b", int'(b_filt), 1);
        tick(150);
        chk("rinit_cnt", int'(glitch_cnt), 0);

        // Narrow-counter instance: 20 glitches saturate at 15
        for (int i = 0; i < 20; i++) begin
            a2 = 1'b1;
            tick(2);
            a2 = 1'b0;
            tick(6);
            if (i == 2) chk("sat_cnt3", int'(cnt2), 3);
            if (i == 14) chk("sat_cnt15", int'(cnt2), 15);
        end
        chk("sat_cnt20", int'(cnt2), 15);
        chk("sat_a_filt", int'(a_filt2), 0);
        chk("sat_b_filt", int'(b_filt2), 0);
        chk("sat_stb", int'(stb2), 0);
        chk("sat_err", int'(err2), 0);

        chk("final_pending", exq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
